// File: rtl/spi_sd_responder_pkg.sv
// Shared types and constants for the SPI-mode SD responder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package spi_sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        WAIT,
        SEND
    } state_e;

    localparam int         FRAME_LEN  = 6;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam logic [7:0] START_MASK = 8'hC0;
    localparam logic [7:0] START_VAL  = 8'h40;
    localparam logic [6:0] CRC7_POLY  = 7'h09;

    // One byte of CRC7 (x^7+x^3+1), MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] din);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ din[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_sd_responder_if.sv
// Local-side command/response bundle of the SD responder.
// Latency: n/a (wiring only).
// Backpressure: resp_valid/resp_ready handshake; cmd_* is a fire-and-forget pulse.
// Ports: cmd_valid/index/arg/crc_err and busy flow out of the responder;
// resp_valid/data/last flow in, resp_ready flows out.
interface spi_sd_responder_if;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_crc_err;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_last;
    logic        resp_ready;
    logic        busy;

    // Responder side.
    modport slave (
        output cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready, busy,
        input  resp_valid, resp_data, resp_last
    );

    // Local logic side.
    modport master (
        input  cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready, busy,
        output resp_valid, resp_data, resp_last
    );
endinterface

// File: rtl/spi_sd_responder_crc7.sv
// Bytewise CRC7 accumulator with clear and enable.
// Latency: 1 clock from en to updated crc.
// Backpressure: none; clr together with en restarts from zero with din.
// Ports: clock/reset, clr, en, din[7:0] -> crc[6:0].
module spi_crc7
    import spi_sd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)     crc_d = en ? crc7_byte(7'd0, din) : 7'd0;
        else if (en) crc_d = crc7_byte(crc_q, din);
    end

    always_ff @(posedge clock) begin
        if (reset) crc_q <= 7'd0;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/spi_sd_responder.sv
// SPI-mode SD card responder: collects 6-byte command frames, shifts back supplied response bytes.
// Latency: cmd_valid one clock after the frame's last bit is sampled; response follows >= NCR_MIN filler bytes.
// Backpressure: one-byte holding register; resp_ready low while full; empty register in SEND sends 0xFF.
// Ports: clock, reset (sync, active high), spi_clock/spi_cs_n/spi_mosi in, spi_miso/spi_miso_oe out,
// loc = local command/response bundle (slave modport).
// Optional: define SPI_CRC7_CHECK_EN to check the frame CRC7; otherwise cmd_crc_err is tied 0.
module spi_sd_responder
    import spi_sd_pkg::*;
#(
    parameter int NCR_MIN     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic spi_clock,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    spi_sd_responder_if.slave loc
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic        sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, frame_cnt_q, frame_cnt_d;
    logic [3:0]  ncr_cnt_q, ncr_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic        miso_q, miso_d, oe_q, oe_d;
    logic        hold_full_q, hold_full_d, hold_last_q, hold_last_d, last_loaded_q, last_loaded_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic [5:0]  idx_sh_q, idx_sh_d, cmd_index_q, cmd_index_d;
    logic [31:0] arg_sh_q, arg_sh_d, cmd_arg_q, cmd_arg_d;
    logic        cmd_valid_q, cmd_valid_d, crc_err_q, crc_err_d;

    logic sclk_s, cs_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done, is_start;
    logic resp_ready, crc_mismatch;
    logic [7:0] rx_byte;
    logic [3:0] ncr_n;
    logic       send_now;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall = cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;
    // SPI clock edges only count while selected; a select edge takes the cycle for itself.
    assign sclk_rise = ~cs_s & ~cs_fall & sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~cs_s & ~cs_fall & ~sclk_s & sclk_prev_q;
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};
    assign is_start  = (rx_byte & START_MASK) == START_VAL;
    assign ncr_n     = (ncr_cnt_q == 4'(NCR_MIN)) ? ncr_cnt_q : ncr_cnt_q + 4'd1;
    // Hold byte goes out at this boundary if SEND, or if this boundary ends the last filler byte.
    assign send_now  = hold_full_q && !last_loaded_q &&
                       (state_q == SEND || (state_q == WAIT && ncr_n == 4'(NCR_MIN)));
    assign resp_ready = !hold_full_q && (state_q == WAIT || (state_q == SEND && !last_loaded_q));

`ifdef SPI_CRC7_CHECK_EN
    logic [6:0] crc;
    spi_crc7 u_crc7 (
        .clock (clock),
        .reset (reset),
        .clr   (byte_done && state_q == IDLE && !cs_rise),
        .en    (byte_done && !cs_rise && ((state_q == IDLE && is_start) ||
                (state_q == FRAME && frame_cnt_q != 3'(FRAME_LEN - 1)))),
        .din   (rx_byte),
        .crc   (crc)
    );
    assign crc_mismatch = (rx_byte[7:1] != crc) || !rx_byte[0];
`else
    assign crc_mismatch = 1'b0;
`endif

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_clock};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d   = sclk_s;
        cs_prev_d     = cs_s;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        ncr_cnt_d     = ncr_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        oe_d          = oe_q;
        hold_full_d   = hold_full_q;
        hold_last_d   = hold_last_q;
        hold_dat_d    = hold_dat_q;
        last_loaded_d = last_loaded_q;
        idx_sh_d      = idx_sh_q;
        arg_sh_d      = arg_sh_q;
        cmd_index_d   = cmd_index_q;
        cmd_arg_d     = cmd_arg_q;
        crc_err_d     = crc_err_q;
        cmd_valid_d   = 1'b0;

        if (cs_fall) begin
            bit_cnt_d  = 3'd0;
            tx_shift_d = FILL_BYTE;
            oe_d       = 1'b1;
        end else if (cs_rise) begin
            // Abort: drop the transaction without reporting it.
            state_d       = IDLE;
            hold_full_d   = 1'b0;
            last_loaded_d = 1'b0;
            oe_d          = 1'b0;
            miso_d        = 1'b1;
        end else begin
            if (sclk_fall) begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
            if (loc.resp_valid && resp_ready) begin
                hold_full_d = 1'b1;
                hold_dat_d  = loc.resp_data;
                hold_last_d = loc.resp_last;
            end
            // Late response: filler quota already met, start sending at the next boundary.
            if (state_q == WAIT && ncr_cnt_q == 4'(NCR_MIN) && hold_full_q) state_d = SEND;
            if (sclk_rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                tx_shift_d = send_now ? hold_dat_q : FILL_BYTE;
                if (send_now) begin
                    hold_full_d   = 1'b0;
                    last_loaded_d = hold_last_q;
                end
                case (state_q)
                    IDLE: if (is_start) begin
                        idx_sh_d    = rx_byte[5:0];
                        frame_cnt_d = 3'd1;
                        state_d     = FRAME;
                    end
                    FRAME: begin
                        frame_cnt_d = frame_cnt_q + 3'd1;
                        if (frame_cnt_q == 3'(FRAME_LEN - 1)) begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = idx_sh_q;
                            cmd_arg_d   = arg_sh_q;
                            crc_err_d   = crc_mismatch;
                            ncr_cnt_d   = 4'd0;
                            state_d     = WAIT;
                        end else begin
                            arg_sh_d = {arg_sh_q[23:0], rx_byte};
                        end
                    end
                    WAIT: begin
                        ncr_cnt_d = ncr_n;
                        if (send_now) state_d = SEND;
                    end
                    SEND: if (last_loaded_q) begin
                        last_loaded_d = 1'b0;
                        state_d       = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            frame_cnt_q   <= 3'd0;
            ncr_cnt_q     <= 4'd0;
            rx_shift_q    <= 8'd0;
            tx_shift_q    <= 8'd0;
            miso_q        <= 1'b1;
            oe_q          <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_last_q   <= 1'b0;
            hold_dat_q    <= 8'd0;
            last_loaded_q <= 1'b0;
            idx_sh_q      <= 6'd0;
            arg_sh_q      <= 32'd0;
            cmd_index_q   <= 6'd0;
            cmd_arg_q     <= 32'd0;
            crc_err_q     <= 1'b0;
            cmd_valid_q   <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            ncr_cnt_q     <= ncr_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            hold_full_q   <= hold_full_d;
            hold_last_q   <= hold_last_d;
            hold_dat_q    <= hold_dat_d;
            last_loaded_q <= last_loaded_d;
            idx_sh_q      <= idx_sh_d;
            arg_sh_q      <= arg_sh_d;
            cmd_index_q   <= cmd_index_d;
            cmd_arg_q     <= cmd_arg_d;
            crc_err_q     <= crc_err_d;
            cmd_valid_q   <= cmd_valid_d;
        end
    end

    assign spi_miso        = miso_q;
    assign spi_miso_oe     = oe_q;
    assign loc.cmd_valid   = cmd_valid_q;
    assign loc.cmd_index   = cmd_index_q;
    assign loc.cmd_arg     = cmd_arg_q;
    assign loc.cmd_crc_err = crc_err_q;
    assign loc.resp_ready  = resp_ready;
    assign loc.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_sd_responder.sv
// Bench for spi_sd_responder: SPI master model, response feeder, table-driven command checks.
// Latency: n/a (testbench).
// Backpressure: the feeder honours resp_ready.
module tb_spi_sd_responder;
    logic clock = 1'b0;
    logic reset, spi_clock, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
    spi_sd_responder_if sif();

    spi_sd_responder #(.NCR_MIN(1), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_clock   (spi_clock),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .loc         (sif)
    );

    always #5 clock = ~clock;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cv_cnt = 0;
    logic cv_err = 1'b0;

    typedef struct {
        int          lead;
        logic [47:0] frame;
        logic [5:0]  idx;
        logic [31:0] arg;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected CRC verdict: computed from the frame bytes, only when checking is built in.
    function automatic logic crc_err_model(input logic [47:0] f);
`ifdef SPI_CRC7_CHECK_EN
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 47; i >= 8; i--) begin
            fb = c[6] ^ f[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return (f[7:1] != c) || !f[0];
`else
        return (f[0] & 1'b0);
`endif
    endfunction

    always @(negedge clock) begin
        if (sif.cmd_valid) begin
            cv_cnt++;
            cv_err = sif.cmd_crc_err;
        end
    end

    // Response feeder: {last, data} entries, offered while resp_en is set.
    logic [8:0] rq[$];
    logic       resp_en = 1'b0;
    logic       commit  = 1'b0;
    always @(negedge clock) begin
        if (commit && rq.size() > 0) void'(rq.pop_front());
        if (resp_en && rq.size() > 0) begin
            sif.resp_valid = 1'b1;
            sif.resp_data  = rq[0][7:0];
            sif.resp_last  = rq[0][8];
        end else begin
            sif.resp_valid = 1'b0;
            sif.resp_data  = 8'h00;
            sif.resp_last  = 1'b0;
        end
        commit = sif.resp_valid && sif.resp_ready;
    end

    // Mode-0 master: 8 system clocks per half SPI period.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (8) @(negedge clock);
            r[i] = spi_miso;
            spi_clock = 1'b1;
            repeat (8) @(negedge clock);
            spi_clock = 1'b0;
        end
        rx = r;
    endtask

    task automatic rd(input string name, input logic [7:0] exp);
        logic [7:0] r;
        xfer(8'hFF, r);
        chk(name, r, exp);
    endtask

    task automatic sel(input logic cs);
        spi_cs_n = cs;
        repeat (16) @(negedge clock);
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic [7:0] r;
        for (int b = 0; b < 6; b++) begin
            xfer(f[47-8*b -: 8], r);
            if (b == 2) begin
                chk("busy_in_frame", sif.busy, 1'b1);
                chk("ready_in_frame", sif.resp_ready, 1'b0);
            end
        end
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         n0;
        logic [7:0] r;
        vt[0] = '{0, 48'h40_00_00_00_00_95, 6'd0,  32'h0000_0000};
        vt[1] = '{2, 48'h51_00_00_02_00_FF, 6'd17, 32'h0000_0200};
        vt[2] = '{0, 48'h40_00_00_00_00_94, 6'd0,  32'h0000_0000};
        vt[3] = '{0, 48'h69_40_00_00_00_77, 6'd41, 32'h4000_0000};
        vt[4] = '{1, 48'h77_00_00_00_00_65, 6'd55, 32'h0000_0000};

        reset = 1'b1; spi_clock = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_miso", spi_miso, 1'b1);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_cmd_valid", sif.cmd_valid, 1'b0);
        chk("rst_ready", sif.resp_ready, 1'b0);
        chk("rst_busy", sif.busy, 1'b0);
        chk("rst_arg", sif.cmd_arg, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        resp_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            sel(1'b0);
            chk("oe_selected", spi_miso_oe, 1'b1);
            for (int k = 0; k < vt[v].lead; k++) xfer(8'hFF, r);
            n0 = cv_cnt;
            send_frame(vt[v].frame);
            chk("cmd_valid_count", cv_cnt, n0 + 1);
            chk("cmd_index", {26'd0, sif.cmd_index}, {26'd0, vt[v].idx});
            chk("cmd_arg", sif.cmd_arg, vt[v].arg);
            chk("cmd_crc_err", cv_err, crc_err_model(vt[v].frame));
            chk("ready_in_wait", sif.resp_ready, 1'b1);
            rq.push_back(9'h101);
            rd("miso_ncr", 8'hFF);
            rd("miso_r1", 8'h01);
            rd("miso_after", 8'hFF);
            chk("busy_done", sif.busy, 1'b0);
            sel(1'b1);
            chk("oe_deselected", spi_miso_oe, 1'b0);
        end

        // CMD8 with the response held back for two byte times.
        sel(1'b0);
        send_frame(48'h48_00_00_01_AA_87);
        chk("cmd8_index", {26'd0, sif.cmd_index}, 32'd8);
        chk("cmd8_arg", sif.cmd_arg, 32'h0000_01AA);
        resp_en = 1'b0;
        rq.push_back(9'h001); rq.push_back(9'h000); rq.push_back(9'h000);
        rq.push_back(9'h001); rq.push_back(9'h1AA);
        rd("cmd8_b6", 8'hFF);
        rd("cmd8_b7", 8'hFF);
        resp_en = 1'b1;
        rd("cmd8_b8", 8'hFF);
        rd("cmd8_b9", 8'h01);
        rd("cmd8_b10", 8'h00);
        rd("cmd8_b11", 8'h00);
        rd("cmd8_b12", 8'h01);
        rd("cmd8_b13", 8'hAA);
        chk("cmd8_idle", sif.busy, 1'b0);
        sel(1'b1);

        // Abort mid-frame: nothing reported, previous command held.
        sel(1'b0);
        n0 = cv_cnt;
        xfer(8'h40, r); xfer(8'h00, r); xfer(8'h00, r);
        chk("abort_busy_before", sif.busy, 1'b1);
        sel(1'b1);
        chk("abort_no_valid", cv_cnt, n0);
        chk("abort_oe", spi_miso_oe, 1'b0);
        chk("abort_busy", sif.busy, 1'b0);
        chk("abort_miso", spi_miso, 1'b1);
        chk("abort_index_held", {26'd0, sif.cmd_index}, 32'd8);
        sel(1'b0);
        n0 = cv_cnt;
        send_frame(48'h40_00_00_00_00_95);
        chk("post_abort_valid", cv_cnt, n0 + 1);
        chk("post_abort_index", {26'd0, sif.cmd_index}, 32'd0);
        chk("post_abort_arg", sif.cmd_arg, 32'h0);

        // Reset during SEND with a byte parked in the holding register.
        rq.push_back(9'h001); rq.push_back(9'h07E); rq.push_back(9'h13C);
        rd("send_b6", 8'hFF);
        rd("send_b7", 8'h01);
        repeat (6) @(negedge clock);
        chk("send_hold_full", sif.resp_ready, 1'b0);
        chk("send_busy", sif.busy, 1'b1);
        resp_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        rq.delete();
        chk("mid_rst_miso", spi_miso, 1'b1);
        chk("mid_rst_oe", spi_miso_oe, 1'b0);
        chk("mid_rst_valid", sif.cmd_valid, 1'b0);
        chk("mid_rst_err", sif.cmd_crc_err, 1'b0);
        chk("mid_rst_ready", sif.resp_ready, 1'b0);
        chk("mid_rst_busy", sif.busy, 1'b0);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        resp_en = 1'b1;
        sel(1'b0);
        send_frame(48'h40_00_00_00_00_95);
        rq.push_back(9'h101);
        rd("post_rst_ncr", 8'hFF);
        rd("post_rst_r1", 8'h01);
        rd("post_rst_after", 8'hFF);
        sel(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
